// File: rtl/cayde_pkg.sv
// cayde_pkg: shared widths, address/data types and write-back source encoding.
package cayde_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NREGS = 2 ** REG_AW;
  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;
  typedef enum logic {WB_ALU = 1'b0, WB_LSU = 1'b1} wb_src_e;
endpackage

// File: rtl/cayde_rr_arb2.sv
// cayde_rr_arb2: two-way round-robin arbiter; the pointer only moves on contention.
module cayde_rr_arb2 import cayde_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  wb_src_e rr;
  // A lone request (or none) passes straight through; contention goes to rr.
  always_comb gnt = (&req) ? ((rr == WB_LSU) ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clk) begin
    if (rst) rr <= WB_ALU;
    else if (&req) rr <= (rr == WB_ALU) ? WB_LSU : WB_ALU;
  end
endmodule

// File: rtl/cayde_wb_sched.sv
// cayde_wb_sched: register-file write-port scheduler with busy scoreboard and hazard stall.
module cayde_wb_sched import cayde_pkg::*; (
  input  logic      clk,
  input  logic      rst,
  input  logic      iss_valid,
  input  reg_addr_t iss_rd,
  input  reg_addr_t dec_rs1,
  input  reg_addr_t dec_rs2,
  input  reg_addr_t dec_rd,
  output logic      stall_out,
  input  logic      alu_valid,
  output logic      alu_ready,
  input  reg_addr_t alu_addr,
  input  xlen_t     alu_data,
  input  logic      lsu_valid,
  output logic      lsu_ready,
  input  reg_addr_t lsu_addr,
  input  xlen_t     lsu_data,
  output logic      rf_wen,
  output reg_addr_t rf_waddr,
  output xlen_t     rf_wdata,
  output logic      err_unclaimed
);
  logic [1:0] gnt;
  logic [NREGS-1:0] busy, busy_nx;
  logic granted;
  reg_addr_t wb_addr;
  xlen_t wb_data;
  cayde_rr_arb2 u_arb (
    .clk(clk),
    .rst(rst),
    .req({lsu_valid, alu_valid}),
    .gnt(gnt)
  );
  assign alu_ready = gnt[0] & ~rst;
  assign lsu_ready = gnt[1] & ~rst;
  assign granted = alu_ready | lsu_ready;
  assign wb_addr = gnt[1] ? lsu_addr : alu_addr;
  assign wb_data = gnt[1] ? lsu_data : alu_data;
  // Bit 0 is never set, so x0 operands never stall.
  assign stall_out = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];
  // Set is applied after clear: a fresh issue owns the register over a retiring write.
  always_comb begin
    busy_nx = busy;
    if (rf_wen) busy_nx[rf_waddr] = 1'b0;
    if (iss_valid && iss_rd != '0) busy_nx[iss_rd] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      rf_wen <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      err_unclaimed <= 1'b0;
    end else begin
      busy <= busy_nx;
      rf_wen <= granted && wb_addr != '0;
      if (granted) begin
        rf_waddr <= wb_addr;
        rf_wdata <= wb_data;
      end
      if (granted && wb_addr != '0 && !busy[wb_addr]) err_unclaimed <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cayde_wb_sched.sv
// tb_cayde_wb_sched: directed tables, corner sequences and randomized traffic against a reference model.
module tb_cayde_wb_sched;
  import cayde_pkg::*;
  logic clk = 0, rst = 1;
  logic iss_valid = 0, alu_valid = 0, lsu_valid = 0;
  reg_addr_t iss_rd = 0, dec_rs1 = 0, dec_rs2 = 0, dec_rd = 0, alu_addr = 0, lsu_addr = 0;
  xlen_t alu_data = 0, lsu_data = 0;
  logic stall_out, alu_ready, lsu_ready, rf_wen, err_unclaimed;
  reg_addr_t rf_waddr;
  xlen_t rf_wdata;
  int n_chk = 0, n_err = 0;
  bit m_busy [NREGS];
  int m_rr, m_pa, m_g;
  bit m_pv, m_err, m_known;
  logic [31:0] m_pd;
  logic s_ar, s_lr, s_stall, s_wen, s_err;
  logic [31:0] s_waddr, s_wdata;
  typedef struct {bit av, lv, ar, lr, wen; int waddr;} vec_t;
  vec_t tbl [5];

  cayde_wb_sched dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .stall_out(stall_out),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err_unclaimed(err_unclaimed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hazard(input int r);
    return r != 0 && m_busy[r];
  endfunction

  // One clock: compare everything against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int ga;
    logic [31:0] gd;
    @(negedge clk);
    s_ar = alu_ready; s_lr = lsu_ready; s_stall = stall_out; s_wen = rf_wen;
    s_err = err_unclaimed; s_waddr = 32'(rf_waddr); s_wdata = rf_wdata;
    m_g = -1;
    if (!rst) m_g = (alu_valid && lsu_valid) ? m_rr : alu_valid ? 0 : lsu_valid ? 1 : -1;
    if (m_known) begin
      chk("alu_ready", 32'(s_ar), 32'(m_g == 0));
      chk("lsu_ready", 32'(s_lr), 32'(m_g == 1));
      chk("stall_out", 32'(s_stall), 32'(hazard(dec_rs1) || hazard(dec_rs2) || hazard(dec_rd)));
      chk("rf_wen", 32'(s_wen), 32'(m_pv && m_pa != 0));
      if (m_pv && m_pa != 0) begin
        chk("rf_waddr", s_waddr, 32'(m_pa));
        chk("rf_wdata", s_wdata, m_pd);
      end
      chk("err_unclaimed", 32'(s_err), 32'(m_err));
    end
    @(posedge clk);
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_rr = 0; m_pv = 0; m_pa = 0; m_pd = 0; m_err = 0; m_known = 1;
    end else begin
      ga = (m_g == 1) ? int'(lsu_addr) : int'(alu_addr);
      gd = (m_g == 1) ? lsu_data : alu_data;
      if (m_g >= 0 && ga != 0 && !m_busy[ga]) m_err = 1;
      if (m_pv && m_pa != 0) m_busy[m_pa] = 0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
      if (alu_valid && lsu_valid) m_rr = 1 - m_rr;
      m_pv = m_g >= 0; m_pa = ga; m_pd = gd;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  initial begin
    tbl[0] = '{1, 1, 1, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 1, 1, 3};
    tbl[2] = '{1, 1, 1, 0, 1, 4};
    tbl[3] = '{1, 1, 0, 1, 1, 3};
    tbl[4] = '{0, 0, 0, 0, 1, 4};
    m_known = 0;
    rst = 1;
    cycle();
    do_reset();
    dec_rs1 = 5; dec_rs2 = 6; dec_rd = 7;
    cycle();
    chk("reset rf_wen", 32'(s_wen), 0);
    chk("reset rf_waddr", s_waddr, 0);
    chk("reset rf_wdata", s_wdata, 0);
    chk("reset stall", 32'(s_stall), 0);
    chk("reset err", 32'(s_err), 0);
    // single ALU write to x5
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    iss_valid = 1; iss_rd = 5;
    cycle();
    iss_valid = 0; dec_rs1 = 5;
    cycle();
    chk("single stall set", 32'(s_stall), 1);
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    cycle();
    chk("single alu_ready", 32'(s_ar), 1);
    alu_valid = 0;
    cycle();
    chk("single rf_wen", 32'(s_wen), 1);
    chk("single rf_waddr", s_waddr, 5);
    chk("single rf_wdata", s_wdata, 32'hDEADBEEF);
    chk("single stall held", 32'(s_stall), 1);
    cycle();
    chk("single stall clear", 32'(s_stall), 0);
    // contention table after a fresh reset
    dec_rs1 = 0;
    do_reset();
    iss_valid = 1; iss_rd = 3;
    cycle();
    iss_rd = 4;
    cycle();
    iss_valid = 0;
    alu_addr = 3; alu_data = 32'h11; lsu_addr = 4; lsu_data = 32'h22;
    for (int i = 0; i < 5; i++) begin
      alu_valid = tbl[i].av; lsu_valid = tbl[i].lv;
      cycle();
      chk($sformatf("tbl%0d alu_ready", i), 32'(s_ar), 32'(tbl[i].ar));
      chk($sformatf("tbl%0d lsu_ready", i), 32'(s_lr), 32'(tbl[i].lr));
      chk($sformatf("tbl%0d rf_wen", i), 32'(s_wen), 32'(tbl[i].wen));
      if (tbl[i].wen) chk($sformatf("tbl%0d rf_waddr", i), s_waddr, 32'(tbl[i].waddr));
    end
    // x0 write is accepted but dropped
    do_reset();
    lsu_valid = 1; lsu_addr = 0; lsu_data = 32'hFFFFFFFF;
    cycle();
    chk("x0 lsu_ready", 32'(s_lr), 1);
    lsu_valid = 0;
    cycle();
    chk("x0 rf_wen", 32'(s_wen), 0);
    chk("x0 err", 32'(s_err), 0);
    // set/clear collision on x9
    iss_valid = 1; iss_rd = 9;
    cycle();
    iss_valid = 0; alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
    cycle();
    alu_valid = 0; iss_valid = 1; iss_rd = 9; dec_rs2 = 9;
    cycle();
    chk("collide rf_wen", 32'(s_wen), 1);
    iss_valid = 0;
    cycle();
    chk("collide stall", 32'(s_stall), 1);
    // reset with a write in the output stage, then an unclaimed write
    alu_valid = 1; alu_addr = 9; alu_data = 32'h1234;
    cycle();
    rst = 1; alu_addr = 12; alu_data = 32'h5678;
    cycle();
    chk("rst-cycle rf_wen", 32'(s_wen), 1);
    chk("rst alu_ready", 32'(s_ar), 0);
    rst = 0;
    cycle();
    chk("post-rst rf_wen", 32'(s_wen), 0);
    chk("post-rst stall", 32'(s_stall), 0);
    chk("unclaimed grant", 32'(s_ar), 1);
    alu_valid = 0;
    cycle();
    chk("unclaimed err", 32'(s_err), 1);
    // randomized traffic, requesters hold until accepted
    dec_rs2 = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(299) == 0);
      iss_valid = $urandom_range(2) == 0; iss_rd = reg_addr_t'($urandom);
      dec_rs1 = reg_addr_t'($urandom); dec_rs2 = reg_addr_t'($urandom); dec_rd = reg_addr_t'($urandom);
      if (!alu_valid || s_ar) begin
        alu_valid = $urandom_range(1); alu_addr = reg_addr_t'($urandom); alu_data = $urandom;
      end
      if (!lsu_valid || s_lr) begin
        lsu_valid = $urandom_range(1); lsu_addr = reg_addr_t'($urandom); lsu_data = $urandom;
      end
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
